// File: rtl/freq_shift_tdm.sv
// freq_shift_tdm
// Time-division-multiplexed complex frequency shifter. Interleaved I/Q
// samples (one per channel, NUM_CH channels) are rotated by their own
// channel's NCO phase, scaled by a common gain, then rounded and saturated.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   iin, qin              signed input sample
//   in_tvalid, in_tlast   input stream valid / end of burst
//   in_tready             input ready (= pipeline enable)
//   cfg_ch, cfg_inc       channel and phase increment to write
//   cfg_wr                one-cycle write strobe
//   gain                  unsigned common gain, unity = 2^(GAIN_WIDTH-2)
//   phase_rst             one-cycle pulse clearing all accumulators
//   iout, qout            shifted output sample
//   out_ch, out_tlast     channel tag / end of burst aligned with the sample
//   out_tvalid            output valid
//   out_tready            downstream ready
module freq_shift_tdm #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int PHASE_WIDTH     = 24,
  parameter int LUT_BITS        = 10,
  parameter int SIN_COS_WIDTH   = 16,
  parameter int GAIN_WIDTH      = 18,
  parameter int BURST_PHASE_RST = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  iin,
  input  logic [DATA_WIDTH-1:0]  qin,
  input  logic                   in_tvalid,
  input  logic                   in_tlast,
  output logic                   in_tready,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [PHASE_WIDTH-1:0] cfg_inc,
  input  logic                   cfg_wr,
  input  logic [GAIN_WIDTH-1:0]  gain,
  input  logic                   phase_rst,
  output logic [DATA_WIDTH-1:0]  iout,
  output logic [DATA_WIDTH-1:0]  qout,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  input  logic                   out_tready
);

  localparam int  MW    = DATA_WIDTH + SIN_COS_WIDTH;
  localparam int  RW    = MW + 1;
  localparam int  PW    = RW + GAIN_WIDTH + 1;
  localparam int  SH    = SIN_COS_WIDTH - 1 + GAIN_WIDTH - 2;
  localparam int  ROM_N = 2 ** LUT_BITS;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((2 ** (SIN_COS_WIDTH - 1)) - 1);

  localparam logic signed [PW-1:0] HALF = PW'(1) << (SH - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  logic                          w_en;
  logic                          w_accept;
  logic                          w_clear;
  logic [LUT_BITS-1:0]           w_addr;
  logic signed [GAIN_WIDTH:0]    w_gainS;
  logic signed [PW-1:0]          w_rndI;
  logic signed [PW-1:0]          w_rndQ;
  logic signed [SIN_COS_WIDTH-1:0] w_cosRom [ROM_N];
  logic signed [SIN_COS_WIDTH-1:0] w_sinRom [ROM_N];

  logic [CH_W-1:0]        r_chCnt;
  logic [PHASE_WIDTH-1:0] r_acc [NUM_CH];
  logic [PHASE_WIDTH-1:0] r_inc [NUM_CH];

  // Sideband per stage: 0 capture, 1 ROM, 2 products, 3 add/sub, 4 gain.
  logic                   r_v    [5];
  logic [CH_W-1:0]        r_ch   [5];
  logic                   r_last [5];
  logic [GAIN_WIDTH-1:0]  r_gain [4];

  logic signed [DATA_WIDTH-1:0]    r_iA, r_qA, r_iB, r_qB;
  logic [LUT_BITS-1:0]             r_addrA;
  logic signed [SIN_COS_WIDTH-1:0] r_cosB, r_sinB;
  logic signed [MW-1:0]            r_ic, r_qs, r_is, r_qc;
  logic signed [RW-1:0]            r_iRot, r_qRot;
  logic signed [PW-1:0]            r_pI, r_pQ;

  // Full-wave sin/cos table computed at elaboration, rounded to nearest.
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam real ANG   = 2.0 * PI * k / real'(ROM_N);
    localparam real COS_R = AMP * $cos(ANG);
    localparam real SIN_R = AMP * $sin(ANG);
    localparam int  COS_I = (COS_R >= 0.0) ? $rtoi(COS_R + 0.5) : -$rtoi(0.5 - COS_R);
    localparam int  SIN_I = (SIN_R >= 0.0) ? $rtoi(SIN_R + 0.5) : -$rtoi(0.5 - SIN_R);
    assign w_cosRom[k] = SIN_COS_WIDTH'(COS_I);
    assign w_sinRom[k] = SIN_COS_WIDTH'(SIN_I);
  end

  // The whole pipeline advances together; a stalled output freezes everything.
  assign w_en      = !out_tvalid | out_tready;
  assign in_tready = w_en;
  assign w_accept  = in_tvalid & w_en;
  assign w_clear   = w_en & (phase_rst | ((BURST_PHASE_RST != 0) & w_accept & in_tlast));
  assign w_addr    = r_acc[r_chCnt][PHASE_WIDTH-1 -: LUT_BITS];
  assign w_gainS   = $signed({1'b0, r_gain[3]});
  assign w_rndI    = (r_pI + HALF) >>> SH;
  assign w_rndQ    = (r_pQ + HALF) >>> SH;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAXV)      sat = MAXV[DATA_WIDTH-1:0];
    else if (v < MINV) sat = MINV[DATA_WIDTH-1:0];
    else               sat = v[DATA_WIDTH-1:0];
  endfunction

  // Channel counter, NCO accumulators and increments. A clear wins over the
  // accumulate, but the sample captured on that edge already read its old phase.
  // Increment writes land after the read, so a same-edge sample uses the old one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chCnt <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_acc[c] <= '0;
        r_inc[c] <= '0;
      end
    end else begin
      if (w_accept) begin
        if (in_tlast || r_chCnt == CH_W'(NUM_CH - 1)) r_chCnt <= '0;
        else                                          r_chCnt <= r_chCnt + CH_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_clear)                                   r_acc[c] <= '0;
        else if (w_accept && r_chCnt == CH_W'(c))      r_acc[c] <= r_acc[c] + r_inc[c];
        if (cfg_wr && cfg_ch == CH_W'(c))              r_inc[c] <= cfg_inc;
      end
    end
  end

  // Datapath: capture + phase address, ROM read, four products, add/sub,
  // gain product. Sideband shifts alongside so tags stay with their sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 5; s++) begin
        r_v[s]    <= 1'b0;
        r_ch[s]   <= '0;
        r_last[s] <= 1'b0;
      end
      for (int s = 0; s < 4; s++) r_gain[s] <= '0;
      r_iA    <= '0;
      r_qA    <= '0;
      r_addrA <= '0;
      r_iB    <= '0;
      r_qB    <= '0;
      r_cosB  <= '0;
      r_sinB  <= '0;
      r_ic    <= '0;
      r_qs    <= '0;
      r_is    <= '0;
      r_qc    <= '0;
      r_iRot  <= '0;
      r_qRot  <= '0;
      r_pI    <= '0;
      r_pQ    <= '0;
    end else if (w_en) begin
      r_v[0]    <= in_tvalid;
      r_ch[0]   <= r_chCnt;
      r_last[0] <= in_tvalid & in_tlast;
      r_gain[0] <= gain;
      for (int s = 1; s < 5; s++) begin
        r_v[s]    <= r_v[s-1];
        r_ch[s]   <= r_ch[s-1];
        r_last[s] <= r_last[s-1];
      end
      for (int s = 1; s < 4; s++) r_gain[s] <= r_gain[s-1];
      r_iA    <= iin;
      r_qA    <= qin;
      r_addrA <= w_addr;
      r_iB    <= r_iA;
      r_qB    <= r_qA;
      r_cosB  <= w_cosRom[r_addrA];
      r_sinB  <= w_sinRom[r_addrA];
      r_ic    <= MW'(r_iB) * MW'(r_cosB);
      r_qs    <= MW'(r_qB) * MW'(r_sinB);
      r_is    <= MW'(r_iB) * MW'(r_sinB);
      r_qc    <= MW'(r_qB) * MW'(r_cosB);
      r_iRot  <= RW'(r_ic) - RW'(r_qs);
      r_qRot  <= RW'(r_is) + RW'(r_qc);
      r_pI    <= PW'(r_iRot) * PW'(w_gainS);
      r_pQ    <= PW'(r_qRot) * PW'(w_gainS);
    end
  end

  // Output registers: round half-up, saturate. Held while downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_ch     <= '0;
      iout       <= '0;
      qout       <= '0;
    end else if (w_en) begin
      out_tvalid <= r_v[4];
      out_tlast  <= r_last[4];
      out_ch     <= r_ch[4];
      iout       <= sat(w_rndI);
      qout       <= sat(w_rndQ);
    end
  end

endmodule

// File: tb/tb_freq_shift_tdm.sv
// Testbench for freq_shift_tdm (instantiated with three channels so the
// channel counter wraps at a non-power-of-two and cfg_ch=3 is out of range).
// Directed vectors use rotations of exact quarter turns so every expected
// output can be worked out by hand.
module tb_freq_shift_tdm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iin, qin;
  logic        in_tvalid, in_tlast, in_tready;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_inc;
  logic        cfg_wr;
  logic [17:0] gain;
  logic        phase_rst;
  logic [15:0] iout, qout;
  logic [1:0]  out_ch;
  logic        out_tvalid, out_tlast, out_tready;

  typedef struct {
    int i; int q; int gain; bit last; bit prst;
    bit wr; int wch; int winc;
    int ei; int eq; int ech; bit elast;
  } vec_t;

  typedef struct { int i; int q; int ch; bit last; } obs_t;

  vec_t vec [16];
  obs_t outQ [$];
  obs_t expQ [$];
  int   total = 0;
  int   bad   = 0;

  localparam int Q1 = 1 << 22;
  localparam int Q2 = 1 << 23;
  localparam int G1 = 1 << 16;

  freq_shift_tdm #(.NUM_CH(3)) dut (
    .clk(clk), .reset(reset), .iin(iin), .qin(qin),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_wr(cfg_wr), .gain(gain),
    .phase_rst(phase_rst), .iout(iout), .qout(qout), .out_ch(out_ch),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tready(out_tready)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void checkOutput(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endfunction

  // Record transfers at the negedge before the handshake edge, and check that a
  // stalled output does not move.
  bit   prevStall = 0;
  int   prevData, prevCtl;
  always @(negedge clk) begin
    if (reset) begin
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("stall data held", {iout, qout}, prevData);
        checkOutput("stall ctl held", int'({out_tvalid, out_ch, out_tlast}), prevCtl);
      end
      if (out_tvalid && out_tready)
        outQ.push_back('{int'($signed(iout)), int'($signed(qout)), int'(out_ch), out_tlast});
      prevStall = out_tvalid && !out_tready;
      prevData  = {iout, qout};
      prevCtl   = int'({out_tvalid, out_ch, out_tlast});
    end
  end

  function automatic void setRow(int k, int i, int q, int g, bit last, bit prst,
                                 int ei, int eq, int ech, bit elast);
    vec[k] = '{i, q, g, last, prst, 1'b0, 0, 0, ei, eq, ech, elast};
  endfunction

  function automatic void rotq(input int i, input int q, input int n, output int oi, output int oq);
    case (n % 4)
      0: begin oi = i;  oq = q;  end
      1: begin oi = -q; oq = i;  end
      2: begin oi = -i; oq = -q; end
      default: begin oi = q; oq = -i; end
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    in_tvalid = 0; in_tlast = 0; phase_rst = 0; cfg_wr = 0;
    reset = 1;
    cycles(2);
    reset = 0;
    outQ.delete();
  endtask

  task automatic cfgWrite(input int ch, input int inc);
    cfg_ch = 2'(ch); cfg_inc = 24'(inc); cfg_wr = 1;
    cycles(1);
    cfg_wr = 0;
  endtask

  // Hold a sample on the input until it is accepted (bounded).
  task automatic applyStimulus(input vec_t v);
    bit acc = 0;
    int n = 0;
    iin = 16'(v.i); qin = 16'(v.q); gain = 18'(v.gain);
    in_tlast = v.last; phase_rst = v.prst;
    cfg_wr = v.wr; cfg_ch = 2'(v.wch); cfg_inc = 24'(v.winc);
    in_tvalid = 1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_tready;
      @(posedge clk);
      #1;
      n++;
    end
    in_tvalid = 0; in_tlast = 0; phase_rst = 0; cfg_wr = 0;
    if (!acc) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic waitOutputs(input int n);
    int c = 0;
    while (outQ.size() < n && c < 300) begin cycles(1); c++; end
    if (outQ.size() < n) checkOutput("drain timeout", outQ.size(), n);
  endtask

  task automatic runTable(input string name, input int n);
    obs_t o;
    for (int k = 0; k < n; k++) applyStimulus(vec[k]);
    waitOutputs(n);
    for (int k = 0; k < n; k++) begin
      if (outQ.size() == 0) break;
      o = outQ.pop_front();
      checkOutput($sformatf("%s[%0d].i", name, k), o.i, vec[k].ei);
      checkOutput($sformatf("%s[%0d].q", name, k), o.q, vec[k].eq);
      checkOutput($sformatf("%s[%0d].ch", name, k), o.ch, vec[k].ech);
      checkOutput($sformatf("%s[%0d].last", name, k), int'(o.last), int'(vec[k].elast));
    end
  endtask

  initial begin
    int ch0I [4];
    int ch0Q [4];
    int lat;
    int qstep [3];
    obs_t o, e;

    reset = 1; iin = 0; qin = 0; in_tvalid = 0; in_tlast = 0;
    cfg_ch = 0; cfg_inc = 0; cfg_wr = 0; gain = 0; phase_rst = 0; out_tready = 1;
    cycles(2);

    // Reset values.
    checkOutput("reset out_tvalid", int'(out_tvalid), 0);
    checkOutput("reset out_tlast", int'(out_tlast), 0);
    checkOutput("reset iout", int'(iout), 0);
    checkOutput("reset qout", int'(qout), 0);
    checkOutput("reset out_ch", int'(out_ch), 0);
    checkOutput("reset in_tready", int'(in_tready), 1);
    reset = 0;

    // Latency: single sample, expect valid exactly five edges after the accept.
    applyStimulus('{1000, 0, G1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    lat = 0;
    for (int e2 = 1; e2 <= 8; e2++) begin
      cycles(1);
      if (out_tvalid && lat == 0) lat = e2;
    end
    checkOutput("latency", lat, 5);
    waitOutputs(1);
    if (outQ.size() > 0) begin
      o = outQ.pop_front();
      checkOutput("latency sample i", o.i, 1000);
      checkOutput("latency sample q", o.q, 0);
    end

    // Quarter-turn NCO on channel 0, other channels static.
    doReset();
    cfgWrite(0, Q1);
    ch0I = '{1000, 0, -1000, 0};
    ch0Q = '{0, 1000, 0, -1000};
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) setRow(k, 1000, 0, G1, 0, 0, ch0I[k/3], ch0Q[k/3], 0, 0);
      else            setRow(k, 1000, 0, G1, 0, 0, 1000, 0, k % 3, 0);
    end
    runTable("quarter", 12);

    // Half-turn on channels 1 and 2.
    doReset();
    cfgWrite(1, Q2);
    cfgWrite(2, Q2);
    setRow(0, 500, -300, G1, 0, 0, 500, -300, 0, 0);
    setRow(1, 500, -300, G1, 0, 0, 500, -300, 1, 0);
    setRow(2, 500, -300, G1, 0, 0, 500, -300, 2, 0);
    setRow(3, 500, -300, G1, 0, 0, 500, -300, 0, 0);
    setRow(4, 500, -300, G1, 0, 0, -500, 300, 1, 0);
    setRow(5, 500, -300, G1, 0, 0, -500, 300, 2, 0);
    runTable("half", 6);

    // Gain, rounding (half-up) and saturation with zero phase.
    doReset();
    setRow(0, 32767, -32768, 1 << 17, 0, 0, 32767, -32768, 0, 0);
    setRow(1, 100, -100, 1 << 17, 0, 0, 200, -200, 1, 0);
    setRow(2, -32768, 32767, 1 << 17, 0, 0, -32768, 32767, 2, 0);
    setRow(3, 32767, -32768, G1, 0, 0, 32766, -32767, 0, 0);
    setRow(4, -32768, 32767, 1 << 15, 0, 0, -16383, 16383, 1, 0);
    setRow(5, 0, 0, G1, 0, 0, 0, 0, 2, 0);
    setRow(6, 1, -1, G1, 0, 0, 1, -1, 0, 0);
    runTable("gain", 7);

    // Burst restart on tlast, then phase_rst on an accept edge.
    doReset();
    cfgWrite(0, Q1);
    cfgWrite(1, Q1);
    cfgWrite(2, Q1);
    setRow(0, 1000, 0, G1, 0, 0, 1000, 0, 0, 0);
    setRow(1, 1000, 0, G1, 1, 0, 1000, 0, 1, 1);
    setRow(2, 1000, 0, G1, 0, 0, 1000, 0, 0, 0);
    setRow(3, 1000, 0, G1, 0, 0, 1000, 0, 1, 0);
    setRow(4, 1000, 0, G1, 0, 0, 1000, 0, 2, 0);
    setRow(5, 1000, 0, G1, 0, 0, 0, 1000, 0, 0);
    setRow(6, 1000, 0, G1, 0, 1, 0, 1000, 1, 0);
    setRow(7, 1000, 0, G1, 0, 0, 1000, 0, 2, 0);
    setRow(8, 1000, 0, G1, 0, 0, 1000, 0, 0, 0);
    runTable("burst", 9);

    // Increment write on the same edge as that channel's sample.
    doReset();
    for (int k = 0; k < 6; k++) setRow(k, 1000, 0, G1, 0, 0, 1000, 0, k % 3, 0);
    vec[0].wr = 1; vec[0].wch = 0; vec[0].winc = Q2;
    setRow(6, 1000, 0, G1, 0, 0, -1000, 0, 0, 0);
    runTable("cfgcoll", 7);

    // Random input gaps plus a ten-cycle downstream stall against a model.
    doReset();
    cfgWrite(0, Q1);
    cfgWrite(1, Q2);
    cfgWrite(2, 0);
    cfgWrite(3, Q1);
    qstep = '{1, 2, 0};
    expQ.delete();
    fork
      begin
        vec_t v;
        int ei, eq;
        for (int k = 0; k < 24; k++) begin
          cycles($urandom_range(0, 2));
          v = '{37 * k - 400, 300 - 23 * k, G1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
          applyStimulus(v);
          rotq(v.i, v.q, (k / 3) * qstep[k % 3], ei, eq);
          expQ.push_back('{ei, eq, k % 3, 1'b0});
        end
      end
      begin
        cycles(10);
        out_tready = 0;
        cycles(5);
        @(negedge clk);
        checkOutput("in_tready during stall", int'(in_tready), 0);
        checkOutput("out_tvalid during stall", int'(out_tvalid), 1);
        cycles(5);
        out_tready = 1;
      end
    join
    waitOutputs(24);
    cycles(10);
    checkOutput("random count", outQ.size(), 24);
    for (int k = 0; k < 24; k++) begin
      if (outQ.size() == 0 || expQ.size() == 0) break;
      o = outQ.pop_front();
      e = expQ.pop_front();
      checkOutput($sformatf("rand[%0d].i", k), o.i, e.i);
      checkOutput($sformatf("rand[%0d].q", k), o.q, e.q);
      checkOutput($sformatf("rand[%0d].ch", k), o.ch, e.ch);
    end

    // Asynchronous reset mid-burst, then a clean restart.
    doReset();
    cfgWrite(0, Q1);
    for (int k = 0; k < 8; k++) applyStimulus('{1000, 0, G1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    checkOutput("pre-reset out_tvalid", int'(out_tvalid), 1);
    #3;
    reset = 1;
    #1;
    checkOutput("async reset out_tvalid", int'(out_tvalid), 0);
    outQ.delete();
    @(posedge clk);
    #1;
    reset = 0;
    applyStimulus('{1000, 0, G1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    waitOutputs(1);
    cycles(10);
    checkOutput("post-reset count", outQ.size(), 1);
    if (outQ.size() > 0) begin
      o = outQ.pop_front();
      checkOutput("post-reset i", o.i, 1000);
      checkOutput("post-reset q", o.q, 0);
      checkOutput("post-reset ch", o.ch, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
